// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
// ID/EX pipeline register feeding the ALU. Decodes a MIPS instruction word
// together with the register-file read data into ALU operands, a 4-bit ALU
// control code, a shift amount and writeback information. The result is
// registered behind a valid/ready handshake.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid / in_ready        upstream handshake (in_ready is combinational)
//   instr, rs_data, rt_data    instruction word and register operands
//   flush                      squash held and incoming instruction
//   out_valid / out_ready      downstream handshake
//   ALU_reg_1, ALU_reg_2       operand A / operand B
//   ALU_control, shamt         ALU operation code and shift amount
//   dest_reg, reg_write        writeback register index and enable
//   illegal_op                 unsupported instruction marker
// ---------------------------------------------------------------------------
module alu_issue_stage #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ALU_reg_1,
    output logic [DATA_W-1:0] ALU_reg_2,
    output logic [CTRL_W-1:0] ALU_control,
    output logic [4:0]        shamt,
    output logic [4:0]        dest_reg,
    output logic              reg_write,
    output logic              illegal_op
);

    localparam logic [CTRL_W-1:0] CTRL_AND = 4'b0000;
    localparam logic [CTRL_W-1:0] CTRL_OR  = 4'b0001;
    localparam logic [CTRL_W-1:0] CTRL_ADD = 4'b0010;
    localparam logic [CTRL_W-1:0] CTRL_SUB = 4'b0110;
    localparam logic [CTRL_W-1:0] CTRL_SLT = 4'b0111;
    localparam logic [CTRL_W-1:0] CTRL_NOR = 4'b1100;
    localparam logic [CTRL_W-1:0] CTRL_SLL = 4'b1111;
    localparam logic [CTRL_W-1:0] CTRL_MUL = 4'b1001;

    logic [5:0]        opcode_s;
    logic [5:0]        funct_s;
    logic [DATA_W-1:0] imm_sx_s;
    logic [DATA_W-1:0] imm_zx_s;
    logic              load_s;

    logic [DATA_W-1:0] alu_a_d,    alu_a_q;
    logic [DATA_W-1:0] alu_b_d,    alu_b_q;
    logic [CTRL_W-1:0] alu_ctrl_d, alu_ctrl_q;
    logic [4:0]        shamt_d,    shamt_q;
    logic [4:0]        dest_d,     dest_q;
    logic              rw_d,       rw_q;
    logic              ill_d,      ill_q;
    logic              valid_q;

    assign opcode_s = instr[31:26];
    assign funct_s  = instr[5:0];
    assign imm_sx_s = {{(DATA_W-16){instr[15]}}, instr[15:0]};
    assign imm_zx_s = {{(DATA_W-16){1'b0}}, instr[15:0]};

    // A held result blocks the input until downstream takes it.
    assign in_ready = !valid_q || out_ready;
    assign load_s   = in_valid && in_ready;

    // Instruction decode into the next-state ALU fields.
    always_comb begin
        alu_a_d    = rs_data;
        alu_b_d    = rt_data;
        alu_ctrl_d = CTRL_AND;
        shamt_d    = 5'd0;
        dest_d     = instr[15:11];
        rw_d       = 1'b1;
        ill_d      = 1'b0;
        case (opcode_s)
            6'h00: begin
                case (funct_s)
                    6'h20, 6'h21: alu_ctrl_d = CTRL_ADD;
                    6'h22, 6'h23: alu_ctrl_d = CTRL_SUB;
                    6'h24:        alu_ctrl_d = CTRL_AND;
                    6'h25:        alu_ctrl_d = CTRL_OR;
                    6'h27:        alu_ctrl_d = CTRL_NOR;
                    6'h2A:        alu_ctrl_d = CTRL_SLT;
                    6'h00: begin
                        alu_ctrl_d = CTRL_SLL;
                        shamt_d    = instr[10:6];
                    end
                    default:      ill_d = 1'b1;
                endcase
            end
            6'h1C: begin
                if (funct_s == 6'h02) begin
                    alu_ctrl_d = CTRL_MUL;
                end else begin
                    ill_d = 1'b1;
                end
            end
            6'h08, 6'h09: begin
                alu_ctrl_d = CTRL_ADD;
                alu_b_d    = imm_sx_s;
                dest_d     = instr[20:16];
            end
            6'h0A: begin
                alu_ctrl_d = CTRL_SLT;
                alu_b_d    = imm_sx_s;
                dest_d     = instr[20:16];
            end
            6'h0C: begin
                alu_ctrl_d = CTRL_AND;
                alu_b_d    = imm_zx_s;
                dest_d     = instr[20:16];
            end
            6'h0D: begin
                alu_ctrl_d = CTRL_OR;
                alu_b_d    = imm_zx_s;
                dest_d     = instr[20:16];
            end
            6'h23: begin
                alu_ctrl_d = CTRL_ADD;
                alu_b_d    = imm_sx_s;
                dest_d     = instr[20:16];
            end
            6'h2B: begin
                alu_ctrl_d = CTRL_ADD;
                alu_b_d    = imm_sx_s;
                dest_d     = instr[20:16];
                rw_d       = 1'b0;
            end
            6'h04: begin
                alu_ctrl_d = CTRL_SUB;
                dest_d     = instr[20:16];
                rw_d       = 1'b0;
            end
            default: ill_d = 1'b1;
        endcase
        // Unsupported encodings carry no operands and never write back.
        if (ill_d) begin
            alu_a_d    = {DATA_W{1'b0}};
            alu_b_d    = {DATA_W{1'b0}};
            alu_ctrl_d = CTRL_AND;
            shamt_d    = 5'd0;
            dest_d     = 5'd0;
            rw_d       = 1'b0;
        end else begin
            alu_a_d    = alu_a_d;
        end
    end

    // Pipeline register: reset, then flush, then load, then empty, else hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            alu_a_q    <= {DATA_W{1'b0}};
            alu_b_q    <= {DATA_W{1'b0}};
            alu_ctrl_q <= {CTRL_W{1'b0}};
            shamt_q    <= 5'd0;
            dest_q     <= 5'd0;
            rw_q       <= 1'b0;
            ill_q      <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
            rw_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else if (load_s) begin
            valid_q    <= 1'b1;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_ctrl_q <= alu_ctrl_d;
            shamt_q    <= shamt_d;
            dest_q     <= dest_d;
            rw_q       <= rw_d;
            ill_q      <= ill_d;
        end else if (out_ready || !valid_q) begin
            valid_q <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            valid_q <= valid_q;
        end
    end

    assign out_valid   = valid_q;
    assign ALU_reg_1   = alu_a_q;
    assign ALU_reg_2   = alu_b_q;
    assign ALU_control = alu_ctrl_q;
    assign shamt       = shamt_q;
    assign dest_reg    = dest_q;
    assign reg_write   = rw_q;
    assign illegal_op  = ill_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] ALU_reg_1;
    logic [DATA_W-1:0] ALU_reg_2;
    logic [CTRL_W-1:0] ALU_control;
    logic [4:0]        shamt;
    logic [4:0]        dest_reg;
    logic              reg_write;
    logic              illegal_op;

    int errors = 0;
    int checks = 0;

    alu_issue_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALU_reg_1(ALU_reg_1), .ALU_reg_2(ALU_reg_2), .ALU_control(ALU_control),
        .shamt(shamt), .dest_reg(dest_reg), .reg_write(reg_write),
        .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [4:0]  sh;
        logic [4:0]  dest;
        logic        rw;
        logic        ill;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Advance past the next rising edge so outputs are sampled away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_fields(input string nm, input vec_t v);
        chk({nm, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({nm, "_a"},     ALU_reg_1, v.a);
        chk({nm, "_b"},     ALU_reg_2, v.b);
        chk({nm, "_ctrl"},  {28'd0, ALU_control}, {28'd0, v.ctrl});
        chk({nm, "_shamt"}, {27'd0, shamt}, {27'd0, v.sh});
        chk({nm, "_dest"},  {27'd0, dest_reg}, {27'd0, v.dest});
        chk({nm, "_rw"},    {31'd0, reg_write}, {31'd0, v.rw});
        chk({nm, "_ill"},   {31'd0, illegal_op}, {31'd0, v.ill});
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({nm, "_a"},     ALU_reg_1, 32'd0);
        chk({nm, "_b"},     ALU_reg_2, 32'd0);
        chk({nm, "_ctrl"},  {28'd0, ALU_control}, 32'd0);
        chk({nm, "_shamt"}, {27'd0, shamt}, 32'd0);
        chk({nm, "_dest"},  {27'd0, dest_reg}, 32'd0);
        chk({nm, "_rw"},    {31'd0, reg_write}, 32'd0);
        chk({nm, "_ill"},   {31'd0, illegal_op}, 32'd0);
        chk({nm, "_inrdy"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        vec_t v_add, v_sub;
        //                instr         rs            rt            A             B             ctrl    sh     dest   rw    ill
        vecs.push_back('{32'h00221820, 32'd5,        32'd7,        32'd5,        32'd7,        4'h2, 5'd0, 5'd3, 1'b1, 1'b0}); // add
        vecs.push_back('{32'h00222022, 32'd5,        32'd7,        32'd5,        32'd7,        4'h6, 5'd0, 5'd4, 1'b1, 1'b0}); // sub
        vecs.push_back('{32'h00221821, 32'hA,        32'hB,        32'hA,        32'hB,        4'h2, 5'd0, 5'd3, 1'b1, 1'b0}); // addu
        vecs.push_back('{32'h00222023, 32'hA,        32'hB,        32'hA,        32'hB,        4'h6, 5'd0, 5'd4, 1'b1, 1'b0}); // subu
        vecs.push_back('{32'h00222824, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hF0F0F0F0, 32'h0FF00FF0, 4'h0, 5'd0, 5'd5, 1'b1, 1'b0}); // and
        vecs.push_back('{32'h00223025, 32'd1,        32'd2,        32'd1,        32'd2,        4'h1, 5'd0, 5'd6, 1'b1, 1'b0}); // or
        vecs.push_back('{32'h00223827, 32'd3,        32'd4,        32'd3,        32'd4,        4'hC, 5'd0, 5'd7, 1'b1, 1'b0}); // nor
        vecs.push_back('{32'h0022402A, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd1,        4'h7, 5'd0, 5'd8, 1'b1, 1'b0}); // slt
        vecs.push_back('{32'h00031100, 32'h11111111, 32'd9,        32'h11111111, 32'd9,        4'hF, 5'd4, 5'd2, 1'b1, 1'b0}); // sll
        vecs.push_back('{32'h70221802, 32'd6,        32'd7,        32'd6,        32'd7,        4'h9, 5'd0, 5'd3, 1'b1, 1'b0}); // mul
        vecs.push_back('{32'h00220020, 32'd5,        32'd7,        32'd5,        32'd7,        4'h2, 5'd0, 5'd0, 1'b1, 1'b0}); // add $0
        vecs.push_back('{32'h2022FFFF, 32'd5,        32'd7,        32'd5,        32'hFFFFFFFF, 4'h2, 5'd0, 5'd2, 1'b1, 1'b0}); // addi -1
        vecs.push_back('{32'h24227FFF, 32'd5,        32'd7,        32'd5,        32'h00007FFF, 4'h2, 5'd0, 5'd2, 1'b1, 1'b0}); // addiu
        vecs.push_back('{32'h28228000, 32'd5,        32'd7,        32'd5,        32'hFFFF8000, 4'h7, 5'd0, 5'd2, 1'b1, 1'b0}); // slti
        vecs.push_back('{32'h30228000, 32'd5,        32'd7,        32'd5,        32'h00008000, 4'h0, 5'd0, 5'd2, 1'b1, 1'b0}); // andi
        vecs.push_back('{32'h34228001, 32'd5,        32'd7,        32'd5,        32'h00008001, 4'h1, 5'd0, 5'd2, 1'b1, 1'b0}); // ori
        vecs.push_back('{32'h8C220004, 32'd100,      32'd7,        32'd100,      32'd4,        4'h2, 5'd0, 5'd2, 1'b1, 1'b0}); // lw
        vecs.push_back('{32'hAC22FFFC, 32'd100,      32'd7,        32'd100,      32'hFFFFFFFC, 4'h2, 5'd0, 5'd2, 1'b0, 1'b0}); // sw
        vecs.push_back('{32'h10220010, 32'd5,        32'd9,        32'd5,        32'd9,        4'h6, 5'd0, 5'd2, 1'b0, 1'b0}); // beq
        vecs.push_back('{32'hFC000000, 32'd5,        32'd7,        32'd0,        32'd0,        4'h0, 5'd0, 5'd0, 1'b0, 1'b1}); // opcode 3F
        vecs.push_back('{32'h0022183F, 32'd5,        32'd7,        32'd0,        32'd0,        4'h0, 5'd0, 5'd0, 1'b0, 1'b1}); // bad funct
        vecs.push_back('{32'h70221803, 32'd5,        32'd7,        32'd0,        32'd0,        4'h0, 5'd0, 5'd0, 1'b0, 1'b1}); // bad special2
        v_add = vecs[0];
        v_sub = vecs[1];

        // Reset held two cycles while upstream offers an instruction.
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        instr = v_add.instr; rs_data = v_add.rs; rt_data = v_add.rt;
        step();
        step();
        chk_zero("reset");

        // Release: first load visible one cycle later.
        rst_n = 1'b1;
        step();
        chk_fields("first_load", v_add);

        // Table sweep, back-to-back with out_ready high.
        for (int i = 0; i < vecs.size(); i++) begin
            instr = vecs[i].instr; rs_data = vecs[i].rs; rt_data = vecs[i].rt;
            in_valid = 1'b1; out_ready = 1'b1;
            chk($sformatf("v%0d_inrdy", i), {31'd0, in_ready}, 32'd1);
            step();
            chk_fields($sformatf("v%0d", i), vecs[i]);
        end

        // Empty: no load with out_ready high drops valid and illegal_op.
        in_valid = 1'b0;
        step();
        chk("empty_valid", {31'd0, out_valid}, 32'd0);
        chk("empty_ill",   {31'd0, illegal_op}, 32'd0);

        // Backpressure: load add, then stall 3 cycles while offering sub.
        in_valid = 1'b1; out_ready = 1'b0;
        instr = v_add.instr; rs_data = v_add.rs; rt_data = v_add.rt;
        step();
        chk_fields("bp_load", v_add);
        instr = v_sub.instr; rs_data = 32'd99; rt_data = 32'd98;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("bp%0d_inrdy", c), {31'd0, in_ready}, 32'd0);
            step();
            chk_fields($sformatf("bp%0d_hold", c), v_add);
        end
        rs_data = v_sub.rs; rt_data = v_sub.rt;
        out_ready = 1'b1;
        #1;
        chk("bp_release_inrdy", {31'd0, in_ready}, 32'd1);
        step();
        chk_fields("bp_second", v_sub);

        // Flush while stalled with a new instruction offered.
        out_ready = 1'b0; in_valid = 1'b1; flush = 1'b1;
        instr = vecs[4].instr; rs_data = vecs[4].rs; rt_data = vecs[4].rt;
        step();
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_rw",    {31'd0, reg_write}, 32'd0);
        chk("flush_ill",   {31'd0, illegal_op}, 32'd0);
        flush = 1'b0; in_valid = 1'b0;
        step();
        chk("flush_dropped", {31'd0, out_valid}, 32'd0);

        // Illegal held under backpressure, then flushed.
        in_valid = 1'b1; out_ready = 1'b0;
        instr = 32'hFC000000; rs_data = 32'd5; rt_data = 32'd7;
        step();
        in_valid = 1'b0;
        step();
        chk("ill_hold_valid", {31'd0, out_valid}, 32'd1);
        chk("ill_hold_ill",   {31'd0, illegal_op}, 32'd1);
        flush = 1'b1;
        step();
        chk("ill_flush_ill",   {31'd0, illegal_op}, 32'd0);
        chk("ill_flush_valid", {31'd0, out_valid}, 32'd0);
        flush = 1'b0;

        // Reset mid-transfer with flush also asserted.
        in_valid = 1'b1; out_ready = 1'b0;
        instr = v_add.instr; rs_data = v_add.rs; rt_data = v_add.rt;
        step();
        chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0; flush = 1'b1;
        step();
        chk_zero("flush_in_reset");
        rst_n = 1'b1; flush = 1'b0; out_ready = 1'b1;
        instr = v_sub.instr; rs_data = v_sub.rs; rt_data = v_sub.rt;
        step();
        chk_fields("post_reset", v_sub);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
